cacheline_adapter: RTL and testbench
====================================

Name: cacheline_adapter

Overview:
- Responder on the 256-bit line interface driven by the memory arbiter (read, write, address, wdata in; rdata, resp out).
- Converts each line request into a 4-beat, 64-bit burst transaction on the physical-memory port.
- Assembles read bursts into one line and serializes write lines into beats.
- Sits between the arbiter and main memory; one transaction in flight at a time.

Parameters:
- LINE_W, 256, cacheline width in bits.
- BEAT_W, 64, memory burst beat width in bits.
- BEATS, LINE_W/BEAT_W (4), beats per line; derived, not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- line_i  in  256  line write data from arbiter.
- line_o  out  256  assembled read line to arbiter.
- address_i  in  32  line byte address from arbiter.
- read_i  in  1  line read request.
- write_i  in  1  line write request.
- resp_o  out  1  one-cycle completion pulse to arbiter.
- burst_i  in  64  read beat from memory.
- burst_o  out  64  write beat to memory.
- address_o  out  32  burst address to memory.
- read_o  out  1  memory read request.
- write_o  out  1  memory write request.
- resp_i  in  1  memory beat acknowledge; one beat transfers per cycle it is high.

Behaviour:
- Decided interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: state=IDLE, beat counter=0, address register=0, write-line register=0, line_o=0. Outputs resp_o, read_o and write_o are 0; burst_o=0; address_o=0. Reset takes priority in every state and aborts any burst mid-operation with no resp_o.
- States:
  - IDLE: no memory request. If read_i is 1, latch {address_i[31:5], 5'b0}, clear counter, go to RD. Else if write_i is 1, latch aligned address and line_i, clear counter, go to WR. read_i has priority when both are high; the write is ignored (protocol violation, arbiter never does this).
  - RD: read_o=1, address_o=latched address. On each cycle with resp_i=1, store burst_i into line_o[BEAT_W*cnt +: BEAT_W] and increment cnt. On the beat with cnt==3, go to DONE.
  - WR: write_o=1, address_o=latched address, burst_o=wline[BEAT_W*cnt +: BEAT_W] (combinational on cnt). On each resp_i=1, increment cnt. On cnt==3 with resp_i=1, go to DONE.
  - DONE: resp_o=1 for exactly one cycle; read_o=0, write_o=0; line_o stable. Go to IDLE.
- Beat order: beat 0 = bits [63:0], ascending.
- Memory holds the beat if resp_i is 0; stalls of any length between beats are legal.
- Latency:
  - Accept cycle: IDLE sees request, registers it.
  - Memory request asserted from the next cycle.
  - resp_o asserted the cycle after the 4th resp_i.
  - With zero-stall memory: read_i sampled at cycle 0, read_o at cycles 1–4, resp_o at cycle 5.
- line_o updates only during RD beats and otherwise holds its last value, including across writes.
- address_i, line_i and request changes after acceptance are ignored until IDLE.
- A request still high in the IDLE cycle after DONE starts a new transaction. The arbiter drops its request after resp_o, so no duplicate occurs.
- Counter is 2 bits and wraps 3→0 on the final beat, so it is always 0 on DONE.
- resp_i while in IDLE or DONE is ignored.

Test Plan:
- Reset, then idle 5 cycles -> resp_o, read_o and write_o are 0; line_o=0; address_o=0.
- Read: read_i=1, address_i=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with no stall -> address_o=0x0000_1220 and read_o high 4 cycles. resp_o pulses one cycle after beat 4 with line_o={0x44..44,0x33..33,0x22..22,0x11..11}.
- Write: write_i=1, address_i=0x8000_0040, line_i={0xD..D,0xC..C,0xB..B,0xA..A}; memory stalls 2 cycles before beat 2 -> burst_o is 0xA..A, 0xB..B (held 3 cycles), 0xC..C, 0xD..D. write_o drops and resp_o pulses once after the 4th resp_i; line_o unchanged.
- Simultaneous read_i=1 and write_i=1 in IDLE -> read burst executes, write_o stays 0.
- rst asserted after 2 read beats -> next cycle state is IDLE, read_o=0, no resp_o. A new read then completes normally, starting at beat 0.
- Back-to-back: read completes, arbiter issues a write the cycle after resp_o -> write accepted in that IDLE cycle and write_o asserted the following cycle.

Source files
------------

// File: rtl/cacheline_adapter.sv
// cacheline_adapter: turns 256-bit line reads/writes into 4-beat 64-bit memory bursts.
// Ports: clk/rst; arbiter side line_i/line_o/address_i/read_i/write_i/resp_o; memory side burst_i/burst_o/address_o/read_o/write_o/resp_i.
module cacheline_adapter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [BEAT_W-1:0] burst_i,
  output logic [BEAT_W-1:0] burst_o,
  output logic [31:0]       address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [LINE_W-1:0] wline_q, wline_d;
  logic [LINE_W-1:0] line_q, line_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wline_d   = wline_q;
    line_d    = line_q;
    read_o    = 1'b0;
    write_o   = 1'b0;
    resp_o    = 1'b0;
    address_o = '0;
    burst_o   = '0;
    unique case (state_q)
      IDLE: begin
        // read wins if both are raised; the write is dropped
        if (read_i) begin
          addr_d  = {address_i[31:OFF_W], OFF_W'(0)};
          cnt_d   = '0;
          state_d = RD;
        end else if (write_i) begin
          addr_d  = {address_i[31:OFF_W], OFF_W'(0)};
          wline_d = line_i;
          cnt_d   = '0;
          state_d = WR;
        end
      end
      RD: begin
        read_o    = 1'b1;
        address_o = addr_q;
        if (resp_i) begin
          line_d[BEAT_W*cnt_q +: BEAT_W] = burst_i;
          // wraps to 0 on the last beat
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) state_d = DONE;
        end
      end
      WR: begin
        write_o   = 1'b1;
        address_o = addr_q;
        burst_o   = wline_q[BEAT_W*cnt_q +: BEAT_W];
        if (resp_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) state_d = DONE;
        end
      end
      DONE: begin
        resp_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign line_o = line_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// tb_cacheline_adapter: directed bench with a scoreboard of expected lines and beats.
// Drives on the falling edge, checks on the falling edge after each rising edge.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int errors = 0;
  int checks = 0;

  logic [255:0] exp_line_q[$];
  logic [63:0]  exp_beat_q[$];
  logic [255:0] model_line;

  cacheline_adapter dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One line transaction with an optional stall before beat stall_beat.
  // For reads, l is the line memory returns; for writes, the line to send.
  task automatic txn(input bit wr, input bit both, input logic [31:0] a,
                     input logic [255:0] l, input int stall_beat,
                     input int stall_n, input string tag);
    logic [31:0] ea;
    int beat;
    int st;
    bit done;
    ea   = {a[31:5], 5'b0};
    beat = 0;
    st   = stall_n;
    done = 1'b0;
    if (wr) begin
      for (int i = 0; i < 4; i++) exp_beat_q.push_back(l[64*i +: 64]);
    end else begin
      model_line = l;
    end
    exp_line_q.push_back(model_line);
    @(negedge clk);
    chk({tag, "_idle_resp"}, resp_o, 0);
    chk({tag, "_idle_rd"}, read_o, 0);
    chk({tag, "_idle_wr"}, write_o, 0);
    read_i    = !wr || both;
    write_i   = wr || both;
    address_i = a;
    line_i    = l;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      read_i    = 1'b0;
      write_i   = 1'b0;
      resp_i    = 1'b0;
      address_i = $urandom;
      line_i    = {8{$urandom}};
      if (resp_o) begin
        chk({tag, "_line"}, line_o, exp_line_q.pop_front());
        chk({tag, "_done_rd"}, read_o, 0);
        chk({tag, "_done_wr"}, write_o, 0);
        done = 1'b1;
      end else begin
        chk({tag, "_read_o"}, read_o, !wr);
        chk({tag, "_write_o"}, write_o, wr);
        chk({tag, "_addr"}, address_o, ea);
        if (wr && exp_beat_q.size() > 0)
          chk({tag, "_burst"}, burst_o, exp_beat_q[0]);
        if (beat == stall_beat && st > 0) begin
          st--;
        end else if (beat < 4) begin
          resp_i = 1'b1;
          if (wr) void'(exp_beat_q.pop_front());
          else burst_i = l[64*beat +: 64];
          beat++;
        end
      end
    end
    if (!done) chk({tag, "_timeout"}, resp_o, 1);
  endtask

  initial begin
    logic [255:0] rd_line;
    logic [255:0] wr_line;
    rst       = 1'b1;
    line_i    = '0;
    address_i = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    burst_i   = '0;
    resp_i    = 1'b0;
    model_line = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    repeat (5) begin
      @(negedge clk);
      chk("rst_resp", resp_o, 0);
      chk("rst_read", read_o, 0);
      chk("rst_write", write_o, 0);
      chk("rst_line", line_o, 0);
      chk("rst_addr", address_o, 0);
      chk("rst_burst", burst_o, 0);
    end

    rd_line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    txn(1'b0, 1'b0, 32'h0000_1234, rd_line, -1, 0, "rd");

    wr_line = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    txn(1'b1, 1'b0, 32'h8000_0040, wr_line, 1, 2, "wr");

    txn(1'b0, 1'b1, 32'h0000_2000, {4{64'h0123_4567_89AB_CDEF}} ^
        {64'h1, 64'h2, 64'h3, 64'h4}, -1, 0, "both");

    // abort a read after two beats
    @(negedge clk);
    read_i    = 1'b1;
    address_i = 32'h0000_0040;
    @(negedge clk);
    read_i = 1'b0;
    chk("abort_read_o", read_o, 1);
    resp_i  = 1'b1;
    burst_i = 64'hDEAD_0000_0000_0001;
    @(negedge clk);
    burst_i = 64'hDEAD_0000_0000_0002;
    @(negedge clk);
    resp_i = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_line = '0;
    chk("abort_rd", read_o, 0);
    chk("abort_resp", resp_o, 0);
    chk("abort_line", line_o, 0);
    chk("abort_addr", address_o, 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_quiet_resp", resp_o, 0);
      chk("abort_quiet_rd", read_o, 0);
    end

    txn(1'b0, 1'b0, 32'h0000_3047, {64'h5555_0000_0000_0004,
        64'h5555_0000_0000_0003, 64'h5555_0000_0000_0002,
        64'h5555_0000_0000_0001}, -1, 0, "rd2");

    // back-to-back: write raised in the IDLE cycle right after resp_o
    txn(1'b0, 1'b0, 32'hFFFF_FFE0, {4{64'hA5A5_5A5A_0F0F_F0F0}} ^
        {64'h0, 64'h10, 64'h200, 64'h3000}, 2, 1, "rd3");
    txn(1'b1, 1'b0, 32'h1234_567F, {64'h4444_0000_0000_0000,
        64'h3333_0000_0000_0000, 64'h2222_0000_0000_0000,
        64'h1111_0000_0000_0000}, -1, 0, "b2b_wr");

    @(negedge clk);
    chk("end_resp", resp_o, 0);
    chk("end_write", write_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
